timekeep_ctrl: RTL and testbench
================================

# timekeep_ctrl

Time-of-day and alarm-setting controller for the alarm clock. It owns the time registers (hour/minute/second) and the alarm registers (hour/minute). It arbitrates the time registers between the 1 Hz timebase and the user's up/down adjust requests, and produces the `match` level that the mode FSM consumes as its alarm trigger. It sits between the button conditioner / mode FSM and the display multiplexer.

## Interface
Parameters:
- `HOUR_MOD`, 24: hour modulus; valid hours are 0..`HOUR_MOD`-1.
- `SNOOZE_MIN`, 5: snooze delay in minutes, valid range 1..59. Used only when `TIMEKEEP_SNOOZE_EN` is defined.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `tick`  in  1  1 Hz timebase pulse, one `clk` wide.
- `adjust`  in  1  mode FSM is in an adjust state.
- `field`  in  2  edit target: 00 time hour, 01 time minute, 10 alarm hour, 11 alarm minute.
- `inc`  in  1  debounced single-cycle increment request.
- `dec`  in  1  debounced single-cycle decrement request.
- `snooze`  in  1  single-cycle snooze request. Ignored unless `TIMEKEEP_SNOOZE_EN` is defined.
- `t_hour`  out  5  time hour.
- `t_min`  out  6  time minute.
- `t_sec`  out  6  time second.
- `a_hour`  out  5  alarm hour.
- `a_min`  out  6  alarm minute.
- `match`  out  1  registered alarm-match level.

## Operation
- Reset: every output is 0 and `tick_pend` is 0. Alarm time 00:00 equals time 00:00, but `match` stays 0 while `adjust`=1; the mode FSM leaves reset in an adjust state.
- Edit request: `inc` or `dec` is accepted only when `adjust`=1. If `inc` and `dec` arrive together, the request is a no-op.
- Edit arithmetic: the selected field wraps with no carry. Minutes go 59↔0. Hours go `HOUR_MOD`-1↔0.
- Time-minute edit: any accepted edit of the time minute also clears `t_sec` to 0.
- Time-field edit freeze: a time field is being edited when `adjust`=1 and `field`[1]=0. In that condition ticks are discarded and time does not advance.
- Tick advance: ticks advance time whenever `adjust`=0, or when `adjust`=1 with `field`[1]=1 (alarm edit; time keeps running).
- Tick carry chain, resolved in one cycle:
  - `t_sec` 59→0 carries into `t_min`.
  - `t_min` 59→0 carries into `t_hour`.
  - `t_hour` `HOUR_MOD`-1→0 with no further carry.
- Arbitration:
  - An accepted time-field edit and a `tick` in the same cycle: the edit wins and the tick is dropped, since time is frozen.
  - An alarm-field edit and a `tick` in the same cycle: both are applied, because they touch disjoint registers.
  - A tick that falls in the same cycle `adjust` falls is latched into `tick_pend` and applied on the next cycle.
  - A second `tick` arriving while `tick_pend`=1 merges into the pending tick. With a 1 Hz timebase this cannot happen.
- `match` is set to 1 when all of the following hold, and to 0 otherwise:
  - `adjust`=0
  - `t_hour`=`a_hour`
  - `t_min`=`a_min`
- `match` therefore stays high for the whole matching minute. The FSM uses its falling edge to re-arm.

## Timing
- Edit latency: an accepted `inc`/`dec` in cycle N updates its register at edge N+1.
- Tick latency: a `tick` in cycle N updates the time registers at edge N+1, or at edge N+2 if it went through `tick_pend`.
- `match` latency: `match` reflects register values one edge after they change.
- Minute rollover: the cycle-N tick that rolls 12:04:59→12:05:00 with alarm 12:05 gives `t_min`=5 at N+1 and `match`=1 at N+2.
- Reset mid-operation: asynchronous. All registers, `tick_pend` and snooze state clear immediately and no pending request survives.

## Configuration
- `TIMEKEEP_SNOOZE_EN` defined:
  - A `snooze` pulse while `match`=1 captures a target equal to the current `t_hour`:`t_min` plus `SNOOZE_MIN`, with hour wrap modulo `HOUR_MOD`. It then sets `snooze_active` and forces `match` to 0 for the rest of the current alarm minute.
  - While `snooze_active`=1, `match` also asserts when the time equals the target.
  - `snooze_active` clears on any of: the target minute being left, an accepted alarm-field edit, or reset.
  - A repeated snooze during a snooze match re-targets to that match time plus `SNOOZE_MIN`.
- `TIMEKEEP_SNOOZE_EN` undefined:
  - The `snooze` port exists but is ignored.
  - No snooze registers are synthesized.

## Structure
- Package `timekeep_pkg` holds:
  - field encoding constants `FLD_TH`, `FLD_TM`, `FLD_AH`, `FLD_AM`
  - `SEC_MOD`=60 and `MIN_MOD`=60
  - width constants `HOUR_W`=5 and `MINSEC_W`=6
- Sub-module `wrap_counter`:
  - parameterized modulus and width
  - ports: load-zero, inc, dec, carry-in; outputs value and carry-out
  - instantiated for seconds, minutes and hours (time), and for hours and minutes (alarm)

## Test plan
- Reset, then `adjust`=0 with 60 ticks → time 00:01:00; `match` goes 1 after reset until the minute changes, then 0 one edge after `t_min`=1.
- Time 23:59:59 and one tick → 00:00:00 at the next edge.
- `adjust`=1, `field`=01 at time 10:30:42, one `dec` → 10:29:00. Then `dec` repeated 30 times → 10:59:00 with `t_hour` unchanged.
- `adjust`=1, `field`=11 with `inc` and `tick` in the same cycle at 08:00:10 → `a_min`+1 and `t_sec`=11 at the same edge. With `field`=01 in the same situation, the tick is dropped and `t_sec`=0.
- `adjust` falling in the same cycle as `tick` → the time advances exactly once, one cycle later. `inc` and `dec` together → no change.
- With `TIMEKEEP_SNOOZE_EN`: alarm 06:00, `snooze` at 06:00:20 → `match`=0 next edge, then `match`=1 at 06:05:00. An alarm edit before 06:05 cancels it.

Source files
------------

// File: rtl/timekeep_pkg.sv
// -----------------------------------------------------------------------------
// timekeep_pkg
// Shared constants for the alarm-clock time-keeping slice: the encoding of the
// edit target, the second/minute moduli and the register widths used for the
// hour and minute/second fields.
// -----------------------------------------------------------------------------
package timekeep_pkg;

  // Edit target selected by the mode FSM. Bit 1 set means an alarm field.
  typedef enum logic [1:0] {
    FLD_TH = 2'b00,  // time hour
    FLD_TM = 2'b01,  // time minute
    FLD_AH = 2'b10,  // alarm hour
    FLD_AM = 2'b11   // alarm minute
  } field_e;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;

  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

endpackage

// File: rtl/timekeep_ctrl_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-MOD up/down counter used for every time and alarm field.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : load zero (highest priority)
//   inc_i     : step up, wrapping MOD-1 -> 0
//   dec_i     : step down, wrapping 0 -> MOD-1
//   cin_i     : carry from the next lower field, counts like inc_i
//   value_o   : current value
//   cout_o    : carry to the next higher field (cin_i while at MOD-1)
// inc_i together with dec_i cancels. Only cin_i can produce a carry-out, so
// user edits wrap a field without touching its neighbour.
// -----------------------------------------------------------------------------
module wrap_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         cin_i,
  output logic [W-1:0] value_o,
  output logic         cout_o
);

  localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;
  logic         up;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    value_d = value_q;
    up      = inc_i | cin_i;
    if (clr_i) begin
      value_d = '0;
    end else if (up && !dec_i) begin
      value_d = (value_q == MAX_VAL) ? '0 : value_q + 1'b1;
    end else if (dec_i && !up) begin
      value_d = (value_q == '0) ? MAX_VAL : value_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;
  assign cout_o  = cin_i && (value_q == MAX_VAL);

endmodule

// File: rtl/timekeep_ctrl.sv
// -----------------------------------------------------------------------------
// timekeep_ctrl
// Owns the time-of-day (hour/minute/second) and alarm (hour/minute) registers,
// arbitrates the time registers between the 1 Hz tick and user adjust
// requests, and produces the registered alarm-match level for the mode FSM.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   tick          : 1 Hz timebase pulse, one clk wide
//   adjust        : mode FSM is in an adjust state
//   field         : edit target (00 t_hour, 01 t_min, 10 a_hour, 11 a_min)
//   inc, dec      : single-cycle edit requests (both together = no-op)
//   snooze        : single-cycle snooze request (snooze build only)
//   t_hour/t_min/t_sec : time of day
//   a_hour/a_min  : alarm time
//   match         : registered alarm-match level
//
// Configuration macro: TIMEKEEP_SNOOZE_EN enables the snooze feature. When it
// is undefined the snooze port is present but ignored and no snooze state
// exists.
// -----------------------------------------------------------------------------
module timekeep_ctrl
  import timekeep_pkg::*;
#(
  parameter int HOUR_MOD   = 24,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                adjust,
  input  logic [1:0]          field,
  input  logic                inc,
  input  logic                dec,
  input  logic                snooze,
  output logic [HOUR_W-1:0]   t_hour,
  output logic [MINSEC_W-1:0] t_min,
  output logic [MINSEC_W-1:0] t_sec,
  output logic [HOUR_W-1:0]   a_hour,
  output logic [MINSEC_W-1:0] a_min,
  output logic                match
);

  logic adjust_q;
  logic tick_pend_q, tick_pend_d;
  logic match_q, match_d;

  logic edit_ok, time_frozen, adj_fall, apply_tick;
  logic th_edit, tm_edit, ah_edit, am_edit;
  logic sec_co, min_co;
  logic unused_hour_co, unused_ah_co, unused_am_co;
  logic alarm_hit;

  assign edit_ok     = adjust & (inc ^ dec);
  // Editing a time field freezes time: ticks in that state are discarded.
  assign time_frozen = adjust & ~field[1];
  assign adj_fall    = adjust_q & ~adjust;
  // A tick coincident with leaving adjust is deferred one cycle via tick_pend;
  // a later tick while pending merges into the single pending advance.
  assign apply_tick  = ~time_frozen & (tick_pend_q | (tick & ~adj_fall));
  assign tick_pend_d = tick & adj_fall;

  assign th_edit = edit_ok & (field == FLD_TH);
  assign tm_edit = edit_ok & (field == FLD_TM);
  assign ah_edit = edit_ok & (field == FLD_AH);
  assign am_edit = edit_ok & (field == FLD_AM);

  // Time chain. A minute edit also zeroes the seconds; tm_edit and apply_tick
  // are mutually exclusive because a minute edit implies time_frozen.
  wrap_counter #(.MOD(SEC_MOD), .W(MINSEC_W)) u_t_sec (
    .clk(clk), .rst(rst), .clr_i(tm_edit), .inc_i(1'b0), .dec_i(1'b0),
    .cin_i(apply_tick), .value_o(t_sec), .cout_o(sec_co)
  );

  wrap_counter #(.MOD(MIN_MOD), .W(MINSEC_W)) u_t_min (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(tm_edit & inc),
    .dec_i(tm_edit & dec), .cin_i(sec_co), .value_o(t_min), .cout_o(min_co)
  );

  wrap_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_t_hour (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(th_edit & inc),
    .dec_i(th_edit & dec), .cin_i(min_co), .value_o(t_hour),
    .cout_o(unused_hour_co)
  );

  // Alarm registers: edit-only, never carried into.
  wrap_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_a_hour (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(ah_edit & inc),
    .dec_i(ah_edit & dec), .cin_i(1'b0), .value_o(a_hour),
    .cout_o(unused_ah_co)
  );

  wrap_counter #(.MOD(MIN_MOD), .W(MINSEC_W)) u_a_min (
    .clk(clk), .rst(rst), .clr_i(1'b0), .inc_i(am_edit & inc),
    .dec_i(am_edit & dec), .cin_i(1'b0), .value_o(a_min),
    .cout_o(unused_am_co)
  );

  assign alarm_hit = (t_hour == a_hour) && (t_min == a_min);

`ifdef TIMEKEEP_SNOOZE_EN
  logic                snz_active_q, snz_active_d;
  logic                snz_mute_q, snz_mute_d;   // suppresses the minute snoozed in
  logic                tgt_hit_q, tgt_hit_d;     // target matched last cycle
  logic [HOUR_W-1:0]   tgt_hour_q, tgt_hour_d;
  logic [MINSEC_W-1:0] tgt_min_q, tgt_min_d;
  logic [MINSEC_W:0]   min_sum;
  logic [HOUR_W-1:0]   nxt_hour;
  logic [MINSEC_W-1:0] nxt_min;
  logic                snooze_take, tgt_eq, snz_hit, raw_hit;

  always_comb begin
    snooze_take  = snooze & match_q;
    tgt_eq       = (t_hour == tgt_hour_q) && (t_min == tgt_min_q);
    snz_hit      = snz_active_q & tgt_eq;
    raw_hit      = alarm_hit | snz_hit;

    // Snooze target = current hh:mm + SNOOZE_MIN, wrapping the hour.
    min_sum  = {1'b0, t_min} + (MINSEC_W + 1)'(SNOOZE_MIN);
    nxt_hour = t_hour;
    nxt_min  = min_sum[MINSEC_W-1:0];
    if (min_sum >= (MINSEC_W + 1)'(MIN_MOD)) begin
      nxt_min  = MINSEC_W'(min_sum - (MINSEC_W + 1)'(MIN_MOD));
      nxt_hour = (t_hour == HOUR_W'(HOUR_MOD - 1)) ? '0 : t_hour + 1'b1;
    end

    snz_active_d = snz_active_q;
    tgt_hour_d   = tgt_hour_q;
    tgt_min_d    = tgt_min_q;
    tgt_hit_d    = snz_hit;
    // The mute lasts until the minute that was snoozed no longer matches.
    snz_mute_d   = snz_mute_q & raw_hit;

    if (snz_active_q && tgt_hit_q && !tgt_eq) snz_active_d = 1'b0;

    if (snooze_take) begin
      tgt_hour_d   = nxt_hour;
      tgt_min_d    = nxt_min;
      snz_active_d = 1'b1;
      snz_mute_d   = 1'b1;
      tgt_hit_d    = 1'b0;
    end

    if (ah_edit || am_edit) begin
      snz_active_d = 1'b0;
      tgt_hit_d    = 1'b0;
    end

    match_d = ~adjust & raw_hit & ~snz_mute_q & ~snooze_take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snz_active_q <= 1'b0;
      snz_mute_q   <= 1'b0;
      tgt_hit_q    <= 1'b0;
      tgt_hour_q   <= '0;
      tgt_min_q    <= '0;
    end else begin
      snz_active_q <= snz_active_d;
      snz_mute_q   <= snz_mute_d;
      tgt_hit_q    <= tgt_hit_d;
      tgt_hour_q   <= tgt_hour_d;
      tgt_min_q    <= tgt_min_d;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_MIN == 0);
  assign match_d       = ~adjust & alarm_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adjust_q    <= 1'b0;
      tick_pend_q <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      adjust_q    <= adjust;
      tick_pend_q <= tick_pend_d;
      match_q     <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: tb/tb_timekeep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timekeep_ctrl
// Self-checking bench for timekeep_ctrl. A behavioural model keeps the time of
// day as a seconds-of-day count and the alarm as a minutes-of-day count, and
// the outputs are compared against it on every falling clock edge. Directed
// sequences add literal expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_timekeep_ctrl;

  localparam int HM  = 24;
  localparam int DAY = HM * 3600;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, adjust, inc, dec, snooze;
  logic [1:0] field;
  logic [4:0] t_hour, a_hour;
  logic [5:0] t_min, t_sec, a_min;
  logic       match;

  int checks = 0;
  int errors = 0;

  timekeep_ctrl #(.HOUR_MOD(HM), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .tick(tick), .adjust(adjust), .field(field),
    .inc(inc), .dec(dec), .snooze(snooze),
    .t_hour(t_hour), .t_min(t_min), .t_sec(t_sec),
    .a_hour(a_hour), .a_min(a_min), .match(match)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  int m_t;          // seconds since midnight
  int m_a;          // alarm, minutes since midnight
  bit m_pend, m_adj_prev, m_match;
  bit m_match_en = 1'b1;
  bit cmp_en     = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int  h, mi, s, ah, am, d;
    bit  edit, frozen, fall, adv, nmatch;
    if (rst) begin
      m_t = 0; m_a = 0; m_pend = 0; m_adj_prev = 0; m_match = 0;
    end else begin
      nmatch = !adjust && ((m_t / 60) == m_a);
      edit   = adjust && (inc != dec);
      d      = inc ? 1 : -1;
      fall   = m_adj_prev && !adjust;
      frozen = adjust && !field[1];
      adv    = !frozen && (m_pend || (tick && !fall));
      if (adv) m_t = (m_t + 1) % DAY;
      h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
      ah = m_a / 60;  am = m_a % 60;
      if (edit) begin
        case (field)
          2'd0: m_t = ((h + d + HM) % HM) * 3600 + mi * 60 + s;
          2'd1: m_t = h * 3600 + ((mi + d + 60) % 60) * 60;
          2'd2: m_a = ((ah + d + HM) % HM) * 60 + am;
          default: m_a = ah * 60 + (am + d + 60) % 60;
        endcase
      end
      m_pend     = tick && fall;
      m_adj_prev = adjust;
      m_match    = nmatch;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("t_hour", t_hour, m_t / 3600);
      check("t_min",  t_min,  (m_t / 60) % 60);
      check("t_sec",  t_sec,  m_t % 60);
      check("a_hour", a_hour, m_a / 60);
      check("a_min",  a_min,  m_a % 60);
      if (m_match_en) check("match", match, m_match);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic step(input bit tk, input bit adj, input bit [1:0] fld,
                      input bit i, input bit d, input bit sz);
    tick = tk; adjust = adj; field = fld; inc = i; dec = d; snooze = sz;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic edit(input bit [1:0] fld, input bit up, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, fld, up, !up, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tick = 0; adjust = 0; field = 0; inc = 0; dec = 0; snooze = 0;
    @(negedge clk); @(negedge clk);
    check("reset_state", {t_hour, t_min, t_sec, a_hour, a_min, match}, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 60 ticks from reset: match high for minute 00:00, low one edge later.
    ticks(1);
    check("match_after_reset", match, 1);
    check("sec_first_tick", t_sec, 1);
    ticks(59);
    check("min_after_60", t_min, 1);
    check("sec_after_60", t_sec, 0);
    check("match_last_edge", match, 1);
    idle();
    check("match_falls", match, 0);

    // Reach 23:59:59 and roll the day.
    edit(2'd0, 1'b0, 1);
    check("hour_dec_wrap", t_hour, 23);
    edit(2'd1, 1'b0, 2);
    check("min_dec_wrap", t_min, 59);
    idle();
    ticks(59);
    check("t_235959", {t_hour, t_min, t_sec}, {5'd23, 6'd59, 6'd59});
    ticks(1);
    check("t_000000", {t_hour, t_min, t_sec}, 0);

    // 10:30:42, minute dec clears seconds, 30 more wrap to 59.
    edit(2'd0, 1'b1, 10);
    edit(2'd1, 1'b1, 30);
    idle();
    ticks(42);
    check("t_103042", {t_hour, t_min, t_sec}, {5'd10, 6'd30, 6'd42});
    edit(2'd1, 1'b0, 1);
    check("t_102900", {t_hour, t_min, t_sec}, {5'd10, 6'd29, 6'd0});
    edit(2'd1, 1'b0, 30);
    check("t_105900", {t_hour, t_min, t_sec}, {5'd10, 6'd59, 6'd0});

    // 08:00:10, alarm edit and tick together both apply; time edit drops it.
    edit(2'd0, 1'b0, 2);
    edit(2'd1, 1'b1, 1);
    idle();
    ticks(10);
    check("t_080010", {t_hour, t_min, t_sec}, {5'd8, 6'd0, 6'd10});
    step(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("alarm_edit_amin", a_min, 1);
    check("alarm_edit_tick", t_sec, 11);
    step(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    check("time_edit_drop", {t_min, t_sec}, {6'd1, 6'd0});

    // inc and dec together do nothing.
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    check("incdec_tmin", t_min, 1);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    check("incdec_ahour", a_hour, 0);

    // Tick in the cycle adjust falls is applied one cycle later, once.
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("fall_tick_deferred", t_sec, 0);
    idle();
    check("fall_tick_applied", t_sec, 1);
    idle();
    check("fall_tick_once", t_sec, 1);

    // Alarm 12:05, minute rollover from 12:04:59.
    edit(2'd2, 1'b1, 12);
    edit(2'd3, 1'b1, 4);
    edit(2'd0, 1'b1, 4);
    edit(2'd1, 1'b1, 3);
    idle();
    ticks(59);
    check("t_120459", {t_hour, t_min, t_sec}, {5'd12, 6'd4, 6'd59});
    ticks(1);
    check("rollover_tmin", t_min, 5);
    check("rollover_match_lag", match, 0);
    idle();
    check("rollover_match", match, 1);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("match_adjust_low", match, 0);

`ifdef TIMEKEEP_SNOOZE_EN
    // Alarm 06:00, snooze at 06:00:20, rematch at 06:05, edit cancels.
    edit(2'd2, 1'b0, 6);
    edit(2'd3, 1'b0, 5);
    edit(2'd0, 1'b0, 6);
    edit(2'd1, 1'b0, 5);
    idle();
    ticks(20);
    check("snz_alarm_match", match, 1);
    m_match_en = 1'b0;
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("snz_mutes", match, 0);
    ticks(280);
    check("snz_t_0605", {t_hour, t_min, t_sec}, {5'd6, 6'd5, 6'd0});
    check("snz_still_low", match, 0);
    idle();
    check("snz_rematch", match, 1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("snz_retarget_mute", match, 0);
    edit(2'd3, 1'b1, 1);
    idle();
    ticks(300);
    check("snz_t_0610", {t_hour, t_min, t_sec}, {5'd6, 6'd10, 6'd0});
    idle();
    check("snz_cancelled", match, 0);
`endif

    cmp_en = 1'b0;
    tick = 0; adjust = 0; inc = 0; dec = 0; snooze = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
